// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
package onehot_dec_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam int IN_W_DEFAULT = 2;
  localparam int OUT_W        = 2 ** IN_W_DEFAULT;
  localparam int MAX_OUT_W    = 64;

  // Wide enough for any code up to 6 bits; callers truncate to their own width.
  function automatic logic [MAX_OUT_W-1:0] bin2onehot(input logic [5:0] code);
    logic [MAX_OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_buf.sv
// Single-entry valid/ready holding register for the incoming binary code.
module code_buffer_1e #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  // Accept and pop are mutually exclusive: pop only happens while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign in_ready = ~full_reg;
  assign full     = full_reg;
  assign data     = data_reg;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Drives the one-hot line selected by a buffered binary code for HOLD_CYCLES,
// separated by GAP_CYCLES of all-zero output.
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int IN_W        = IN_W_DEFAULT,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_code,
  output logic [2**IN_W-1:0] out_onehot,
  output logic               out_valid,
  output logic               busy
);

  localparam int ONEHOT_W = 2 ** IN_W;
  localparam int CNT_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ONEHOT_W-1:0] onehot_reg, onehot_next;
  logic                valid_reg, valid_next;
  logic                load;
  logic                buf_full;
  logic [IN_W-1:0]     buf_code;
  logic [ONEHOT_W-1:0] load_onehot;

  code_buffer_1e #(.W(IN_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_code),
    .pop      (load),
    .full     (buf_full),
    .data     (buf_code)
  );

  assign load_onehot = ONEHOT_W'(bin2onehot(6'(buf_code)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      onehot_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      onehot_reg <= onehot_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    onehot_next = onehot_reg;
    valid_next  = valid_reg;
    load        = 1'b0;
    if (!en) begin
      // Abort whatever is in progress; the buffered code is kept for later.
      state_next  = IDLE;
      cnt_next    = '0;
      onehot_next = '0;
      valid_next  = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (buf_full) load = 1'b1;
        end
        DRIVE: begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
          end else if (GAP_CYCLES > 0) begin
            state_next  = GAP;
            cnt_next    = GAP_LOAD;
            onehot_next = '0;
            valid_next  = 1'b0;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            state_next  = IDLE;
            onehot_next = '0;
            valid_next  = 1'b0;
          end
        end
        GAP: begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
          else if (buf_full) load = 1'b1;
          else state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      if (load) begin
        state_next  = DRIVE;
        cnt_next    = HOLD_LOAD;
        onehot_next = load_onehot;
        valid_next  = 1'b1;
      end
    end
  end

  assign out_onehot = onehot_reg;
  assign out_valid  = valid_reg;
  assign busy       = (state_reg != IDLE) || buf_full;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: default build and a GAP_CYCLES=0 build side by side.
module tb_onehot_decoder_seq;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'd0;
  logic [3:0] oh0, oh1;
  logic       ov0, ov1, rdy0, rdy1, bsy0, bsy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy0),
    .in_code(in_code), .out_onehot(oh0), .out_valid(ov0), .busy(bsy0)
  );

  onehot_decoder_seq #(.GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy1),
    .in_code(in_code), .out_onehot(oh1), .out_valid(ov1), .busy(bsy1)
  );

  // Reference model: age = cycles since the current pattern was loaded (-1 = idle).
  int         age[2];
  logic [3:0] moh[2];
  bit         mfull[2];
  logic [1:0] mcode[2];
  int         gapc[2] = '{1, 0};

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit was_full;
      bit can_load;
      was_full = mfull[i];
      if (!rst_n) begin
        age[i] = -1; mfull[i] = 1'b0; mcode[i] = 2'd0; moh[i] = 4'd0;
      end else begin
        can_load = (age[i] < 0) || (age[i] + 1 >= HOLD + gapc[i]);
        if (!en) begin
          age[i] = -1;
        end else if (can_load && was_full) begin
          age[i] = 0; moh[i] = 4'b0001 << mcode[i]; mfull[i] = 1'b0;
        end else if (age[i] >= 0) begin
          age[i]++;
          if (age[i] >= HOLD + gapc[i]) age[i] = -1;
        end
        if (in_valid && !was_full) begin
          mfull[i] = 1'b1; mcode[i] = in_code;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp_dut(input int i, input logic [3:0] a_oh, input logic a_v,
                         input logic a_r, input logic a_b);
    logic [3:0] e_oh;
    logic e_v, e_r, e_b;
    e_oh = (age[i] >= 0 && age[i] < HOLD) ? moh[i] : 4'd0;
    e_v  = (e_oh != 4'd0);
    e_r  = !mfull[i];
    e_b  = (age[i] >= 0) || mfull[i];
    n_cmp++;
    if ({a_oh, a_v, a_r, a_b} !== {e_oh, e_v, e_r, e_b}) begin
      n_bad++;
      $display("FAIL model_dut%0d t=%0t: got oh=%b v=%b rdy=%b busy=%b, need oh=%b v=%b rdy=%b busy=%b",
               i, $time, a_oh, a_v, a_r, a_b, e_oh, e_v, e_r, e_b);
    end
    n_cmp++;
    if ($countones(a_oh) > 1) begin
      n_bad++;
      $display("FAIL onehot_dut%0d t=%0t: got oh=%b, need at most one bit set", i, $time, a_oh);
    end
  endtask

  bit         rec_on = 1'b0;
  logic [3:0] rec0[$];
  logic [3:0] rec1[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      cmp_dut(0, oh0, ov0, rdy0, bsy0);
      cmp_dut(1, oh1, ov1, rdy1, bsy1);
    end
    if (rec_on) begin
      rec0.push_back(oh0);
      rec1.push_back(oh1);
    end
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %b, need %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    bit rdy;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = c;
    do begin
      rdy = rdy0;
      tick();
      n++;
    end while (!rdy && n < 100);
    in_valid = 1'b0;
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout code=%0d: accepted=0, need 1", c);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bsy0 || bsy1) && n < 60) begin
      tick();
      n++;
    end
    if (bsy0 || bsy1) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy0=%b busy1=%b, need 0 0", bsy0, bsy1);
    end
  endtask

  task automatic wait_rec(input int len);
    int n;
    n = 0;
    while (rec0.size() < len && n < 100) begin
      tick();
      n++;
    end
    rec_on = 1'b0;
  endtask

  logic [3:0] exp_b2b[15] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1,
                              4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
  logic [3:0] exp_g0[10]  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_onehot", oh0, 4'd0);
    check("reset_valid", 4'(ov0), 4'd0);
    check("reset_ready", 4'(rdy0), 4'd1);
    check("reset_busy", 4'(bsy0), 4'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Single code with a one-cycle gap (dut0) and no gap (dut1).
    send(2'd1);
    for (int k = 0; k < HOLD; k++) begin
      tick();
      check("single_hold", oh0, 4'b0010);
      check("single_hold_g0", oh1, 4'b0010);
    end
    tick();
    check("single_gap", oh0, 4'd0);
    check("single_gap_busy", 4'(bsy0), 4'd1);
    check("single_g0_idle", 4'(bsy1), 4'd0);
    tick();
    check("single_idle", 4'(bsy0), 4'd0);

    // Back-to-back codes 3, 0, 2.
    wait_idle();
    rec0.delete(); rec1.delete();
    send(2'd3);
    rec_on = 1'b1;
    send(2'd0);
    send(2'd2);
    wait_rec(15);
    for (int k = 0; k < 15; k++) begin
      if (k < rec0.size()) check($sformatf("b2b_%0d", k), rec0[k], exp_b2b[k]);
      else check($sformatf("b2b_missing_%0d", k), 4'hF, exp_b2b[k]);
    end

    // No-gap build: codes 1 then 3 run together.
    wait_idle();
    rec0.delete(); rec1.delete();
    send(2'd1);
    rec_on = 1'b1;
    send(2'd3);
    wait_rec(10);
    for (int k = 0; k < 10; k++) begin
      if (k < rec1.size()) check($sformatf("gap0_%0d", k), rec1[k], exp_g0[k]);
      else check($sformatf("gap0_missing_%0d", k), 4'hF, exp_g0[k]);
    end

    // en dropped in the second drive cycle, code buffered while disabled.
    wait_idle();
    send(2'd2);
    tick();
    tick();
    check("en_drive2", oh0, 4'b0100);
    en = 1'b0;
    tick();
    check("en_abort_oh", oh0, 4'd0);
    check("en_abort_busy", 4'(bsy0), 4'd0);
    send(2'd1);
    check("en_buffered_ready", 4'(rdy0), 4'd0);
    tick();
    tick();
    check("en_off_oh", oh0, 4'd0);
    check("en_off_busy", 4'(bsy0), 4'd1);
    en = 1'b1;
    tick();
    check("en_resume", oh0, 4'b0010);
    wait_idle();

    // Asynchronous reset mid-drive with a full buffer.
    send(2'd3);
    send(2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_oh", oh0, 4'd0);
    check("arst_valid", 4'(ov0), 4'd0);
    check("arst_oh_g0", oh1, 4'd0);
    check("arst_ready", 4'(rdy0), 4'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("arst_no_replay", oh0, 4'd0);
    end

    // Every code on its own.
    for (int c = 0; c < 4; c++) begin
      logic [3:0] e;
      e = 4'b0001 << c;
      send(2'(c));
      tick();
      check($sformatf("code_%0d", c), oh0, e);
      wait_idle();
    end

    // Random traffic against the model.
    repeat (400) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 2'($urandom_range(0, 3));
      tick();
    end
    en       = 1'b1;
    in_valid = 1'b0;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, need finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Sequential decoder that receives a binary index and drives the matching one-hot line for a programmed number of cycles.
- It is the other direction of the team's 4-to-2 priority encoder: the encoder's O1/O0 code comes in, and a one-hot request vector goes out.
- A one-entry input buffer with a valid/ready handshake decouples the producer from the output timing.
- The block sits between the encoded request bus and the downstream per-line strobe consumers.

Parameters:
- IN_W, 2: code width; the output is 2**IN_W bits wide (default 4).
- HOLD_CYCLES, 4: cycles each one-hot pattern is driven; must be at least 1.
- GAP_CYCLES, 1: cycles of all-zero output forced between consecutive patterns; 0 is legal (back-to-back).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, outputs are forced to zero.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  buffer can accept; transfer happens on a cycle where in_valid && in_ready.
- in_code  in  IN_W  binary index; bit 1 corresponds to the encoder's O1, bit 0 to O0.
- out_onehot  out  2**IN_W  registered one-hot output; all zero when not driving.
- out_valid  out  1  high exactly while out_onehot is nonzero (DRIVE state).
- busy  out  1  high when state is not IDLE or the buffer is full.

Behaviour:
- Reset (async assert, sync deassert as seen by the flops):
  - state=IDLE, buffer empty, counter=0.
  - out_onehot=0, out_valid=0, in_ready=1, busy=0.
- Buffer:
  - One entry: a code register plus a full flag.
  - in_ready = ~buf_full, combinational from the flop only.
  - A transfer sets buf_full and captures in_code.
  - Accept and load never collide in one cycle, because load requires buf_full=1, which forces in_ready=0.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE -> DRIVE when buf_full && en. On that edge:
    - out_onehot <= 1<<code; out_valid <= 1;
    - counter <= HOLD_CYCLES-1; buf_full <= 0.
  - DRIVE: counter decrements each cycle. When counter==0:
    - If GAP_CYCLES>0: go to GAP, out_onehot <= 0, counter <= GAP_CYCLES-1.
    - If GAP_CYCLES==0 and buf_full && en: reload DRIVE directly with the new code (no zero cycle).
    - Otherwise: go to IDLE, outputs <= 0.
  - GAP: counter decrements. When counter==0:
    - If buf_full && en: go to DRIVE (same load as from IDLE).
    - Otherwise: go to IDLE.
- Latency:
  - Code accepted at edge N; out_onehot valid after edge N+1 if the FSM is in IDLE with en=1.
  - The pattern is held for exactly HOLD_CYCLES clock cycles.
- en low:
  - In any state: on the next edge, out_onehot <= 0, out_valid <= 0, state <= IDLE, counter <= 0. The in-progress drive is aborted and not replayed.
  - The buffer keeps its contents and continues to accept while in_ready=1.
  - Loading resumes on the first edge after en returns high.
- in_code is always in range for power-of-two widths; no out-of-range handling.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES,2)).
- Only one out_onehot bit is ever set. This holds through en toggles and reset mid-drive.
- Reset asserted mid-DRIVE: outputs clear immediately (asynchronously); any buffered code is discarded.

Decomposition:
- Shared package `onehot_dec_pkg`:
  - state enum {IDLE, DRIVE, GAP};
  - localparam OUT_W = 2**IN_W;
  - function `bin2onehot`.
- One sub-module: `code_buffer_1e`, the single-entry valid/ready holding register (data, full flag, in_ready, pop input).
- The FSM and counter stay in the top module.

Test Plan:
- Reset then single code:
  - Stimulus: rst_n low 2 cycles, release; en=1; send code 2'b01 (in_valid one cycle).
  - Required: out_onehot=4'b0010 one cycle after acceptance, held for exactly 4 cycles, then 4'b0000 for 1 GAP cycle; state returns to IDLE; busy falls.
- Back-to-back sequence:
  - Stimulus: codes 3,0,2 offered continuously with in_valid=1.
  - Required:
    - Outputs 4'b1000 x4, 0 x1, 4'b0001 x4, 0 x1, 4'b0100 x4.
    - in_ready low while an entry is pending.
    - No code dropped or duplicated.
- GAP_CYCLES=0 build, codes 1 then 3 preloaded:
  - Required: 4'b0010 x4 immediately followed by 4'b1000 x4, with no zero cycle; out_valid stays high 8 cycles.
- en=0 behaviour:
  - Stimulus: drop en in the 2nd DRIVE cycle of code 2.
  - Required: outputs 0 on the next edge, state IDLE.
  - Stimulus continued: send code 1 while en=0.
  - Required: buffered (in_ready goes 0), no output. After en=1, 4'b0010 appears one cycle later.
- Reset mid-operation:
  - Stimulus: assert rst_n asynchronously mid-DRIVE with a full buffer.
  - Required: out_onehot=0 and out_valid=0 without waiting for a clock; in_ready=1 after release; the buffered code is never output.
- Exhaustive codes:
  - Stimulus: all 4 codes, each isolated.
  - Required: out_onehot == 1<<code, popcount always ≤1 (checked every cycle by assertion).
